// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin transmit scheduler in front of the UART TxUnit.
// Accepts bytes from NUM_REQ requesters over valid/ready, latches the winning
// byte and frame config, then sequences Send/ActiveFlag/DoneFlag. A watchdog
// returns the controller to IDLE if a frame never completes.
module tx_arbiter #(
    parameter int          NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic [NUM_REQ-1:0]     ReqValid,
    input  logic [8*NUM_REQ-1:0]   ReqData,
    input  logic [4*NUM_REQ-1:0]   ReqCfg,
    output logic [NUM_REQ-1:0]     ReqReady,
    output logic [10:0]            TxDataIn,
    output logic                   TxSend,
    output logic                   TxStopBits,
    output logic                   TxDataLength,
    output logic [1:0]             TxParityType,
    input  logic                   TxActive,
    input  logic                   TxDone,
    output logic [2:0]             GrantId,
    output logic                   Busy,
    output logic                   TimeoutErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_BUSY = 2'd3
    } state_e;

    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [2:0]  grant_q, grant_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [3:0]  tx_cfg_q, tx_cfg_d;
    logic        tx_send_q, tx_send_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [31:0] wdog_q, wdog_d;

    // Zero-extended request buses so the winner index always selects in range.
    logic [7:0]  valid_ext;
    logic [63:0] data_ext;
    logic [31:0] cfg_ext;

    logic        win_found;
    logic [2:0]  win_idx;
    logic [3:0]  cand;
    logic [2:0]  ptr_next;
    logic        transfer;
    logic        expire;

    assign valid_ext = 8'(ReqValid);
    assign data_ext  = 64'(ReqData);
    assign cfg_ext   = 32'(ReqCfg);

    // Round-robin search: first valid requester at or after rr_ptr_q, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!win_found && valid_ext[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    assign ptr_next = (win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
    assign transfer = (state_q == ST_IDLE) && win_found;
    assign expire   = ((state_q == ST_SEND) || (state_q == ST_BUSY)) && (wdog_q == WDOG_LAST);

    // State register.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // Next-state logic: the watchdog overrides every in-frame transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (transfer) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (expire)        state_d = ST_IDLE;
                else if (TxActive) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (expire)                   state_d = ST_IDLE;
                else if (TxDone && !TxActive) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: combinational ready, next values of the registered strobes.
    always_comb begin
        ReqReady = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ReqReady[i] = transfer && (win_idx == 3'(i));
        end
        tx_send_d = (state_d == ST_SEND);
        busy_d    = (state_d != ST_IDLE);
        timeout_d = expire;
    end

    // Datapath next values: latch winner on transfer, run the watchdog in frame.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        tx_byte_d = tx_byte_q;
        tx_cfg_d  = tx_cfg_q;
        if (transfer) begin
            rr_ptr_d  = ptr_next;
            grant_d   = win_idx;
            tx_byte_d = data_ext[{win_idx, 3'b000} +: 8];
            tx_cfg_d  = cfg_ext[{win_idx, 2'b00} +: 4];
        end
        // Held at zero in IDLE/LOAD so it starts from zero on SEND entry.
        wdog_d = 32'd0;
        if ((state_q == ST_SEND) || (state_q == ST_BUSY)) begin
            wdog_d = wdog_q + 32'd1;
        end
    end

    // Datapath and output registers; all clear asynchronously so Send drops at once.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            rr_ptr_q  <= 3'd0;
            grant_q   <= 3'd0;
            tx_byte_q <= 8'd0;
            tx_cfg_q  <= 4'd0;
            tx_send_q <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            wdog_q    <= 32'd0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            tx_byte_q <= tx_byte_d;
            tx_cfg_q  <= tx_cfg_d;
            tx_send_q <= tx_send_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
        end
    end

    assign TxDataIn     = {3'b000, tx_byte_q};
    assign TxSend       = tx_send_q;
    assign TxStopBits   = tx_cfg_q[3];
    assign TxDataLength = tx_cfg_q[2];
    assign TxParityType = tx_cfg_q[1:0];
    assign GrantId      = grant_q;
    assign Busy         = busy_q;
    assign TimeoutErr   = timeout_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed bench for tx_arbiter. Expected grants are pushed to
// a scoreboard when requests are driven and popped when Send rises.
module tb_tx_arbiter;

    localparam int          N  = 4;
    localparam int unsigned TO = 100;

    logic             Clock;
    logic             ResetN;
    logic [N-1:0]     ReqValid;
    logic [8*N-1:0]   ReqData;
    logic [4*N-1:0]   ReqCfg;
    logic [N-1:0]     ReqReady;
    logic [10:0]      TxDataIn;
    logic             TxSend;
    logic             TxStopBits;
    logic             TxDataLength;
    logic [1:0]       TxParityType;
    logic             TxActive;
    logic             TxDone;
    logic [2:0]       GrantId;
    logic             Busy;
    logic             TimeoutErr;

    tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .ReqValid     (ReqValid),
        .ReqData      (ReqData),
        .ReqCfg       (ReqCfg),
        .ReqReady     (ReqReady),
        .TxDataIn     (TxDataIn),
        .TxSend       (TxSend),
        .TxStopBits   (TxStopBits),
        .TxDataLength (TxDataLength),
        .TxParityType (TxParityType),
        .TxActive     (TxActive),
        .TxDone       (TxDone),
        .GrantId      (GrantId),
        .Busy         (Busy),
        .TimeoutErr   (TimeoutErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0] gid;
        logic [7:0] data;
        logic [3:0] cfg;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [3:0] c);
        ReqData[8*i +: 8] = d;
        ReqCfg[4*i +: 4]  = c;
    endtask

    task automatic push(input int gid, input logic [7:0] d, input logic [3:0] c);
        exp_t e;
        e.gid  = 3'(gid);
        e.data = d;
        e.cfg  = c;
        sb.push_back(e);
    endtask

    function automatic logic [3:0] tx_cfg();
        return {TxStopBits, TxDataLength, TxParityType};
    endfunction

    // Called at an IDLE negedge with requests driven; returns at the first SEND negedge.
    task automatic start_frame(input logic [N-1:0] exp_rdy, input bit keep_valid);
        #1;
        check("ready_idle", 32'(ReqReady), 32'(exp_rdy));
        @(negedge Clock);
        if (!keep_valid) ReqValid = ReqValid & ~exp_rdy;
        check("load_busy", 32'(Busy), 32'd1);
        check("load_send", 32'(TxSend), 32'd0);
        check("load_terr", 32'(TimeoutErr), 32'd0);
        #1;
        check("load_ready", 32'(ReqReady), 32'd0);
        @(negedge Clock);
        check("send_high", 32'(TxSend), 32'd1);
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            check("grant_id", 32'(GrantId), 32'(cur.gid));
            check("tx_data", 32'(TxDataIn), 32'({3'b000, cur.data}));
            check("tx_cfg", 32'(tx_cfg()), 32'(cur.cfg));
        end
    endtask

    // Plays the TxUnit side from SEND through the return to IDLE.
    task automatic finish_frame(input int act_delay, input bit both, input bit scramble);
        repeat (act_delay) begin
            @(negedge Clock);
            check("send_hold", 32'(TxSend), 32'd1);
        end
        TxActive = 1'b1;
        TxDone   = both;
        @(negedge Clock);
        check("busy_send_low", 32'(TxSend), 32'd0);
        check("busy_busy", 32'(Busy), 32'd1);
        if (scramble) begin
            ReqData = ~ReqData;
            ReqCfg  = ~ReqCfg;
        end
        repeat (3) @(negedge Clock);
        check("busy_hold", 32'(Busy), 32'd1);
        check("hold_data", 32'(TxDataIn), 32'({3'b000, cur.data}));
        check("hold_cfg", 32'(tx_cfg()), 32'(cur.cfg));
        TxActive = 1'b0;
        TxDone   = 1'b1;
        @(negedge Clock);
        check("idle_busy", 32'(Busy), 32'd0);
        check("idle_send", 32'(TxSend), 32'd0);
        TxDone = 1'b0;
    endtask

    task automatic do_reset();
        ResetN   = 1'b0;
        ReqValid = '0;
        TxActive = 1'b0;
        TxDone   = 1'b0;
        repeat (2) @(negedge Clock);
        ResetN = 1'b1;
        @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=stuck expected=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [N-1:0] rr_exp [5];
        int send_cnt;
        int pulses;

        ResetN   = 1'b0;
        ReqValid = '0;
        ReqData  = '0;
        ReqCfg   = '0;
        TxActive = 1'b0;
        TxDone   = 1'b0;

        // Reset values.
        @(negedge Clock);
        check("rst_send", 32'(TxSend), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_gid", 32'(GrantId), 32'd0);
        check("rst_data", 32'(TxDataIn), 32'd0);
        check("rst_cfg", 32'(tx_cfg()), 32'd0);
        check("rst_terr", 32'(TimeoutErr), 32'd0);
        check("rst_ready", 32'(ReqReady), 32'd0);
        ResetN = 1'b1;
        @(negedge Clock);

        // Single request: A5 with StopBits=0, DataLength=1, Parity=01.
        set_req(0, 8'hA5, 4'b0101);
        ReqValid = 4'b0001;
        push(0, 8'hA5, 4'b0101);
        start_frame(4'b0001, 1'b0);
        check("single_len", 32'(TxDataLength), 32'd1);
        check("single_par", 32'(TxParityType), 32'd1);
        finish_frame(2, 1'b0, 1'b0);

        // Round-robin with all requesters held valid.
        do_reset();
        set_req(0, 8'h11, 4'h1);
        set_req(1, 8'h22, 4'h6);
        set_req(2, 8'h33, 4'hA);
        set_req(3, 8'h44, 4'hF);
        ReqValid = 4'b1111;
        push(0, 8'h11, 4'h1);
        push(1, 8'h22, 4'h6);
        push(2, 8'h33, 4'hA);
        push(3, 8'h44, 4'hF);
        push(0, 8'h11, 4'h1);
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) begin
            start_frame(rr_exp[k], 1'b1);
            if (k == 4) ReqValid = '0;
            finish_frame(k % 3, 1'b0, 1'b0);
        end

        // Pointer wrap: grant 2 moves the pointer to 3, then 0011 grants 0 then 1.
        set_req(2, 8'h3C, 4'h9);
        ReqValid = 4'b0100;
        push(2, 8'h3C, 4'h9);
        start_frame(4'b0100, 1'b0);
        finish_frame(1, 1'b0, 1'b0);
        set_req(0, 8'h5A, 4'h2);
        set_req(1, 8'h96, 4'h4);
        ReqValid = 4'b0011;
        push(0, 8'h5A, 4'h2);
        push(1, 8'h96, 4'h4);
        start_frame(4'b0001, 1'b0);
        finish_frame(0, 1'b0, 1'b0);
        start_frame(4'b0010, 1'b0);
        finish_frame(3, 1'b0, 1'b0);

        // Config stability: request inputs change while BUSY.
        set_req(0, 8'hC3, 4'b1010);
        ReqValid = 4'b0001;
        push(0, 8'hC3, 4'b1010);
        start_frame(4'b0001, 1'b0);
        finish_frame(1, 1'b0, 1'b1);
        check("idle_data_hold", 32'(TxDataIn), 32'h0C3);
        check("idle_cfg_hold", 32'(tx_cfg()), 32'hA);

        // ActiveFlag and DoneFlag together in SEND: only SEND->BUSY is taken.
        set_req(1, 8'h77, 4'h5);
        ReqValid = 4'b0010;
        push(1, 8'h77, 4'h5);
        start_frame(4'b0010, 1'b0);
        finish_frame(0, 1'b1, 1'b0);

        // Watchdog: ActiveFlag never rises.
        set_req(2, 8'hE1, 4'h3);
        set_req(0, 8'h0F, 4'hC);
        ReqValid = 4'b0101;
        push(2, 8'hE1, 4'h3);
        start_frame(4'b0100, 1'b1);
        send_cnt = 1;
        pulses   = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge Clock);
            if (TxSend)     send_cnt++;
            if (TimeoutErr) pulses++;
            if (!Busy) break;
        end
        check("to_send_cycles", 32'(send_cnt), 32'd100);
        check("to_pulses", 32'(pulses), 32'd1);
        check("to_idle", 32'(Busy), 32'd0);
        check("to_send_low", 32'(TxSend), 32'd0);
        push(0, 8'h0F, 4'hC);
        start_frame(4'b0001, 1'b0);
        finish_frame(0, 1'b0, 1'b0);
        push(2, 8'hE1, 4'h3);
        start_frame(4'b0100, 1'b0);
        finish_frame(0, 1'b0, 1'b0);

        // Asynchronous reset in BUSY, then a fresh grant from pointer 0.
        set_req(3, 8'hB4, 4'h7);
        ReqValid = 4'b1000;
        push(3, 8'hB4, 4'h7);
        start_frame(4'b1000, 1'b0);
        TxActive = 1'b1;
        @(negedge Clock);
        check("pre_rst_busy", 32'(Busy), 32'd1);
        #2;
        ResetN = 1'b0;
        #1;
        check("arst_send", 32'(TxSend), 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_gid", 32'(GrantId), 32'd0);
        check("arst_data", 32'(TxDataIn), 32'd0);
        TxActive = 1'b0;
        @(negedge Clock);
        ResetN = 1'b1;
        set_req(2, 8'h69, 4'hE);
        ReqValid = 4'b0100;
        push(2, 8'h69, 4'hE);
        start_frame(4'b0100, 1'b0);
        finish_frame(2, 1'b0, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
